// File: rtl/adder16_bist.sv
// ---------------------------------------------------------------------------
// adder16_bist
//
// Built-in self test driver and checker for an external 16-bit adder.
// After an accepted start it applies NUM_VECTORS operand pairs (one per
// clock) from two independent 16-bit Fibonacci LFSRs. On every compare edge
// it checks the result the adder returned for the vector that was applied
// during the previous cycle. Mismatches produce an err pulse and a
// saturating count. A single pass/fail verdict is published in DONE.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst_n      : asynchronous active-low reset
//   start      : level-sampled run request (honoured in IDLE and DONE only)
//   a, b       : operands driven to the adder under test (0 when not busy)
//   sum, co    : result returned by the adder under test
//   busy       : high while vectors are being applied/checked (RUN, CHECK)
//   done       : high in DONE
//   pass       : high in DONE when no vector mismatched
//   err        : one-cycle pulse following each mismatching compare edge
//   err_count  : mismatches seen in the current or last run, saturating
// ---------------------------------------------------------------------------
module adder16_bist #(
  parameter int unsigned NUM_VECTORS = 200,
  parameter logic [15:0] SEED_A      = 16'hACE1,
  parameter logic [15:0] SEED_B      = 16'h1D2C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] a,
  output logic [15:0] b,
  input  logic [15:0] sum,
  input  logic        co,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err,
  output logic [7:0]  err_count
);

  // An all-zero LFSR state would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_A_EFF = (SEED_A == 16'h0000) ? 16'h0001 : SEED_A;
  localparam logic [15:0] SEED_B_EFF = (SEED_B == 16'h0000) ? 16'h0001 : SEED_B;
  // Index of the final vector; reaching it in RUN moves the FSM to CHECK.
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Fibonacci LFSR step, taps 16/14/13/11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Saturating increment of the mismatch counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    if (cnt == 8'hFF) begin
      sat_inc = 8'hFF;
    end else begin
      sat_inc = cnt + 8'd1;
    end
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] a_r, a_nxt_s;
  logic [15:0] b_r, b_nxt_s;
  logic [15:0] vec_cnt_r, vec_cnt_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;
  logic        pass_r, pass_nxt_s;
  logic        err_r, err_nxt_s;
  logic [7:0]  err_count_r, err_count_nxt_s;

  logic [16:0] expected_s;
  logic        mismatch_s;
  logic [7:0]  count_after_s;
  logic [15:0] vec_cnt_inc_s;

  // Reference sum of the applied vector and result comparison.
  always_comb begin
    expected_s = {1'b0, a_r} + {1'b0, b_r};
    // Written as if/else so that an unknown result bit falls into the
    // mismatch branch instead of propagating as X.
    if ({co, sum} == expected_s) begin
      mismatch_s = 1'b0;
    end else begin
      mismatch_s = 1'b1;
    end
    if (mismatch_s) begin
      count_after_s = sat_inc(err_count_r);
    end else begin
      count_after_s = err_count_r;
    end
    vec_cnt_inc_s = vec_cnt_r + 16'd1;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt_s     = state_r;
    a_nxt_s         = a_r;
    b_nxt_s         = b_r;
    vec_cnt_nxt_s   = vec_cnt_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = done_r;
    pass_nxt_s      = pass_r;
    err_nxt_s       = 1'b0;
    err_count_nxt_s = err_count_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_nxt_s         = SEED_A_EFF;
          b_nxt_s         = SEED_B_EFF;
          vec_cnt_nxt_s   = 16'd0;
          busy_nxt_s      = 1'b1;
          done_nxt_s      = 1'b0;
          pass_nxt_s      = 1'b0;
          err_count_nxt_s = 8'd0;
          // With a single vector the start edge already applies the last one.
          if (LAST_IDX == 16'd0) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          a_nxt_s = 16'h0000;
          b_nxt_s = 16'h0000;
        end
      end

      ST_RUN: begin
        // Check the vector applied last cycle and apply the next one.
        err_nxt_s       = mismatch_s;
        err_count_nxt_s = count_after_s;
        a_nxt_s         = lfsr_next(a_r);
        b_nxt_s         = lfsr_next(b_r);
        vec_cnt_nxt_s   = vec_cnt_inc_s;
        if (vec_cnt_inc_s == LAST_IDX) begin
          state_nxt_s = ST_CHECK;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end

      ST_CHECK: begin
        // Operands were held for this cycle; only the final compare remains.
        err_nxt_s       = mismatch_s;
        err_count_nxt_s = count_after_s;
        a_nxt_s         = 16'h0000;
        b_nxt_s         = 16'h0000;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b1;
        if (count_after_s == 8'd0) begin
          pass_nxt_s = 1'b1;
        end else begin
          pass_nxt_s = 1'b0;
        end
        state_nxt_s = ST_DONE;
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        a_nxt_s         = 16'h0000;
        b_nxt_s         = 16'h0000;
        vec_cnt_nxt_s   = 16'd0;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        pass_nxt_s      = 1'b0;
        err_count_nxt_s = 8'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand, counter and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= 16'h0000;
      b_r         <= 16'h0000;
      vec_cnt_r   <= 16'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      err_r       <= 1'b0;
      err_count_r <= 8'd0;
    end else begin
      a_r         <= a_nxt_s;
      b_r         <= b_nxt_s;
      vec_cnt_r   <= vec_cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      pass_r      <= pass_nxt_s;
      err_r       <= err_nxt_s;
      err_count_r <= err_count_nxt_s;
    end
  end

  assign a         = a_r;
  assign b         = b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err       = err_r;
  assign err_count = err_count_r;

endmodule
